// File: rtl/fir_host_seq_if.sv
// Sample/result streams, FIR engine bus and frame status between the sequencer and its neighbours.
// The master modport is the sequencer's view; slave is the source/sink/engine side.
interface fir_host_seq_if #(
    parameter int DW = 16,
    parameter int AW = 16
);
    logic          go;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic [1:0]    fir_ctrl;
    logic [DW-1:0] fir_din;
    logic [AW-1:0] fir_addr;
    logic [DW-1:0] fir_dout;
    logic          fir_bsy;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        input  go, in_valid, in_data, out_ready, fir_dout, fir_bsy,
        output in_ready, out_valid, out_data, fir_ctrl, fir_din, fir_addr, busy, done, err
    );

    modport slave (
        output go, in_valid, in_data, out_ready, fir_dout, fir_bsy,
        input  in_ready, out_valid, out_data, fir_ctrl, fir_din, fir_addr, busy, done, err
    );
endinterface

// File: rtl/fir_host_seq.sv
// FIR engine initiator: clear, load N samples, start, poll bsy, read N results out. go->in_ready 3 cycles.
// in_valid gaps stall the load and out_ready low stalls readback, both indefinitely; poll wait is bounded.
module fir_host_seq #(
    parameter int N       = 36,
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int STRIDE  = 4,
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 4096
) (
    input  logic           clk,
    input  logic           rst,
    fir_host_seq_if.master bus
);
    localparam int KW = $clog2(N + 1);
    localparam int PW = $clog2(TIMEOUT + 1);
    localparam int WW = $clog2(RD_LAT + 1);

    typedef enum logic [3:0] {
        IDLE, CLR, GAP, LOAD, LOAD0, START, STOP, SETTLE, POLL, RADDR, RWAIT, EMIT
    } state_t;

    state_t        state;
    logic [KW-1:0] k;
    logic [PW-1:0] pcnt;
    logic [WW-1:0] wcnt;
    logic [DW-1:0] s0;
    logic [AW-1:0] addr_k1;
    logic [AW-1:0] addr_k2;

    assign addr_k1 = AW'((32'(k) + 32'd1) * 32'(STRIDE));
    assign addr_k2 = AW'((32'(k) + 32'd2) * 32'(STRIDE));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            k             <= '0;
            pcnt          <= '0;
            wcnt          <= '0;
            s0            <= '0;
            bus.fir_ctrl  <= 2'b00;
            bus.fir_din   <= '0;
            bus.fir_addr  <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        bus.fir_ctrl <= 2'b10;
                        bus.busy     <= 1'b1;
                        bus.err      <= 1'b0;
                        state        <= CLR;
                    end
                end
                CLR: begin
                    bus.fir_ctrl <= 2'b00;
                    state        <= GAP;
                end
                GAP: begin
                    bus.in_ready <= 1'b1;
                    k            <= '0;
                    state        <= LOAD;
                end
                LOAD: begin
                    if (bus.in_valid && bus.in_ready) begin
                        bus.fir_din  <= bus.in_data;
                        bus.fir_addr <= addr_k1;
                        if (k == '0) begin
                            s0 <= bus.in_data;
                        end
                        if (k == KW'(N - 1)) begin
                            bus.in_ready <= 1'b0;
                            state        <= LOAD0;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                // Word 0 goes last so the engine sees every sample before the start pulse.
                LOAD0: begin
                    bus.fir_din  <= s0;
                    bus.fir_addr <= '0;
                    state        <= START;
                end
                START: begin
                    bus.fir_ctrl <= 2'b01;
                    state        <= STOP;
                end
                STOP: begin
                    bus.fir_ctrl <= 2'b00;
                    state        <= SETTLE;
                end
                SETTLE: begin
                    pcnt  <= '0;
                    state <= POLL;
                end
                // Read address is presented during RADDR, giving the engine RD_LAT+1 cycles before capture.
                POLL: begin
                    if (!bus.fir_bsy) begin
                        k            <= '0;
                        bus.fir_addr <= AW'(STRIDE);
                        state        <= RADDR;
                    end else if (pcnt == PW'(TIMEOUT - 1)) begin
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                RADDR: begin
                    wcnt  <= '0;
                    state <= RWAIT;
                end
                RWAIT: begin
                    if (wcnt == WW'(RD_LAT - 1)) begin
                        bus.out_data  <= bus.fir_dout;
                        bus.out_valid <= 1'b1;
                        state         <= EMIT;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (k == KW'(N - 1)) begin
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            k            <= k + 1'b1;
                            bus.fir_addr <= addr_k2;
                            state        <= RADDR;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_host_seq.sv
// Directed bench for fir_host_seq with a small FIR engine model (dout = addr/4+100 after two registers).
module tb_fir_host_seq;
    localparam int N     = 36;
    localparam int TMO   = 64;
    localparam int STALL = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fir_host_seq_if #(.DW(16), .AW(16)) bus ();

    fir_host_seq #(.N(N), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Engine model: busy for bsy_hold cycles after a start pulse (forever when stuck).
    int          bsy_hold  = 5;
    bit          bsy_stuck = 1'b0;
    int          bcnt      = 0;
    logic [15:0] pipe1     = '0;
    always @(posedge clk) begin
        if (!rst) begin
            pipe1        <= '0;
            bus.fir_dout <= '0;
            bus.fir_bsy  <= 1'b0;
            bcnt         <= 0;
        end else begin
            pipe1        <= bus.fir_addr / 16'd4 + 16'd100;
            bus.fir_dout <= pipe1;
            if (bus.fir_ctrl == 2'b01) begin
                bus.fir_bsy <= 1'b1;
                bcnt        <= bsy_hold;
            end else if (bus.fir_bsy && !bsy_stuck) begin
                if (bcnt <= 1) bus.fir_bsy <= 1'b0;
                else           bcnt <= bcnt - 1;
            end
        end
    end

    // Bus monitor: write events inside the clear..start window, pulse counts, key cycle stamps.
    int          cyc = 0;
    bit          win = 1'b0;
    logic [15:0] prev_a = '0;
    logic [15:0] prev_d = '0;
    logic [31:0] wq[$];
    int          evc[$];
    int          c10 = 0, c01 = 0, done_cnt = 0;
    int          start_cyc = 0, fall_cyc = -1, rd_cyc = -1, err_cyc = -1;
    bit          err_q = 1'b0;
    always @(negedge clk) begin
        cyc    <= cyc + 1;
        prev_a <= bus.fir_addr;
        prev_d <= bus.fir_din;
        if (win && bus.fir_ctrl == 2'b00 && (bus.fir_addr != prev_a || bus.fir_din != prev_d)) begin
            wq.push_back({bus.fir_addr, bus.fir_din});
            evc.push_back(cyc);
        end
        if (bus.fir_ctrl == 2'b10) begin
            c10 <= c10 + 1;
            win <= 1'b1;
        end
        if (bus.fir_ctrl == 2'b01) begin
            c01       <= c01 + 1;
            win       <= 1'b0;
            start_cyc <= cyc;
            fall_cyc  <= -1;
            rd_cyc    <= -1;
        end else begin
            if (fall_cyc < 0 && !bus.fir_bsy && cyc > start_cyc) fall_cyc <= cyc;
            if (rd_cyc < 0 && bus.fir_addr != '0) rd_cyc <= cyc;
        end
        if (bus.done) done_cnt <= done_cnt + 1;
        err_q <= bus.err;
        if (bus.err && !err_q) err_cyc <= cyc;
    end

    // Result sink with an optional STALL-cycle hold on one result index.
    bit          sink_en  = 1'b1;
    int          stall_at = -1;
    int          st       = 0;
    int          st_total = 0;
    int          bp_viol  = 0;
    logic [15:0] hd = '0;
    logic [15:0] ha = '0;
    logic [15:0] outs[$];
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!sink_en) begin
                bus.out_ready = 1'b0;
            end else if (bus.out_valid && outs.size() == stall_at && st < STALL) begin
                if (st == 0) begin
                    hd = bus.out_data;
                    ha = bus.fir_addr;
                end else if (bus.out_data !== hd || bus.fir_addr !== ha) begin
                    bp_viol++;
                end
                st++;
                st_total++;
                bus.out_ready = 1'b0;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                outs.push_back(bus.out_data);
                st = 0;
            end
        end
    end

    task automatic chk_idle_outputs();
        chk("rst_fir_ctrl", bus.fir_ctrl, 0);
        chk("rst_fir_din", bus.fir_din, 0);
        chk("rst_fir_addr", bus.fir_addr, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
    endtask

    // Pulse go, check the clear/gap/first-ready timing, then stream samples 1..N.
    task automatic run_frame(input bit tog);
        int i = 0;
        int guard = 0;
        bit ph = 1'b0;
        @(negedge clk);
        bus.go = 1'b1;
        @(negedge clk);
        bus.go = 1'b0;
        chk("clr_ctrl", bus.fir_ctrl, 2'b10);
        chk("clr_err", bus.err, 0);
        chk("clr_busy", bus.busy, 1);
        chk("clr_in_ready", bus.in_ready, 0);
        @(negedge clk);
        chk("gap_ctrl", bus.fir_ctrl, 2'b00);
        chk("gap_in_ready", bus.in_ready, 0);
        while (i < N && guard < 1000) begin
            @(negedge clk);
            guard++;
            if (guard == 1) chk("go_to_ready_lat", bus.in_ready, 1);
            bus.in_valid = tog ? !ph : 1'b1;
            ph = !ph;
            bus.in_data = 16'(i + 1);
            if (bus.in_valid && bus.in_ready) i++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("samples_accepted", i, N);
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        while (bus.done !== 1'b1 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk(tag, bus.done, 1);
        chk("busy_at_done", bus.busy, 0);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
    endtask

    task automatic chk_writes(input int eb);
        chk("wr_count", wq.size() - eb, N + 1);
        if (wq.size() - eb == N + 1) begin
            for (int i = 0; i < N; i++)
                chk("wr_sample", wq[eb + i], {16'((i + 1) * 4), 16'(i + 1)});
            chk("wr_s0", wq[eb + N], 32'h0000_0001);
            chk("wr_last_to_s0", evc[eb + N] - evc[eb + N - 1], 1);
            chk("s0_to_start", start_cyc - evc[eb + N], 1);
        end
    endtask

    task automatic chk_outs(input int ob);
        chk("out_count", outs.size() - ob, N);
        for (int i = 0; i < N; i++)
            if (ob + i < outs.size()) chk("out_data", outs[ob + i], 101 + i);
    endtask

    initial begin
        int ob, eb, d0, c10_0, c01_0, st0, bv0, g;
        bus.go       = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst          = 1'b0;
        repeat (2) @(negedge clk);
        bus.go = 1'b1;
        @(negedge clk);
        chk_idle_outputs();
        bus.go = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        chk("go_in_reset_ignored", bus.busy, 0);

        // Nominal frame
        ob = outs.size(); eb = wq.size(); d0 = done_cnt; c10_0 = c10; c01_0 = c01;
        run_frame(1'b0);
        wait_done("nom_done");
        chk_writes(eb);
        chk_outs(ob);
        chk("nom_clr_pulses", c10 - c10_0, 1);
        chk("nom_start_pulses", c01 - c01_0, 1);
        chk("nom_done_pulses", done_cnt - d0, 1);
        chk("nom_err", bus.err, 0);

        // Input stall: in_valid alternates
        ob = outs.size(); eb = wq.size();
        run_frame(1'b1);
        wait_done("stall_done");
        chk_writes(eb);
        if (wq.size() - eb > 1) chk("stall_write_spacing", evc[eb + 1] - evc[eb], 2);
        chk_outs(ob);

        // Engine busy for 50 cycles
        bsy_hold = 50;
        ob = outs.size();
        run_frame(1'b0);
        wait_done("bh_done");
        chk("bh_bsy_len", fall_cyc - start_cyc, 51);
        chk("bh_first_read", rd_cyc - fall_cyc, 1);
        chk_outs(ob);
        bsy_hold = 5;

        // Output backpressure on result 3
        ob = outs.size(); st0 = st_total; bv0 = bp_viol;
        stall_at = ob + 2;
        run_frame(1'b0);
        wait_done("bp_done");
        stall_at = -1;
        chk("bp_stall_cycles", st_total - st0, STALL);
        chk("bp_hold_stable", bp_viol - bv0, 0);
        chk_outs(ob);

        // Poll timeout
        bsy_stuck = 1'b1;
        d0 = done_cnt;
        run_frame(1'b0);
        g = 0;
        while (bus.err !== 1'b1 && g < 500) begin
            @(negedge clk);
            g++;
        end
        chk("to_err", bus.err, 1);
        chk("to_busy", bus.busy, 0);
        @(negedge clk);
        chk("to_poll_cycles", err_cyc - start_cyc, TMO + 2);
        repeat (5) @(negedge clk);
        chk("to_no_done", done_cnt - d0, 0);
        chk("to_err_sticky", bus.err, 1);
        bsy_stuck = 1'b0;
        ob = outs.size(); eb = wq.size();
        run_frame(1'b0);
        wait_done("after_to_done");
        chk("after_to_err", bus.err, 0);
        chk_writes(eb);
        chk_outs(ob);

        // Reset while a result is waiting in EMIT
        sink_en = 1'b0;
        run_frame(1'b0);
        g = 0;
        while (bus.out_valid !== 1'b1 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        chk("rm_in_emit", bus.out_valid, 1);
        rst    = 1'b0;
        bus.go = 1'b1;
        @(negedge clk);
        chk_idle_outputs();
        rst    = 1'b1;
        bus.go = 1'b0;
        @(negedge clk);
        chk("rm_go_ignored", bus.busy, 0);
        chk("rm_ctrl_idle", bus.fir_ctrl, 0);
        sink_en = 1'b1;
        ob = outs.size(); eb = wq.size();
        run_frame(1'b0);
        wait_done("rm_fresh_done");
        chk_writes(eb);
        chk_outs(ob);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fir_host_seq.md
Name: fir_host_seq

Overview:
- Hardware initiator for the memory-mapped FIR engine: the host side of its clk/rst/ctrl/din/addr/dout/bsy interface.
- Accepts a frame of N input samples on a valid/ready stream and writes them into the engine's address space.
- Pulses start, polls bsy until the run completes, then reads the N results back and emits them on an output valid/ready stream.
- Sits between the sample source/sink and the fir instance, replacing software-driven load/run/poll/readback.

Parameters:
- N, 36: samples per frame; results per frame.
- DW, 16: sample/result width.
- AW, 16: engine address width.
- STRIDE, 4: address step per word; word k (0-based) lives at (k+1)*STRIDE.
- RD_LAT, 2: cycles from addr change to valid dout.
- TIMEOUT, 4096: max poll cycles before error.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- go  in  1  single-cycle frame start request; sampled only in IDLE.
- in_valid  in  1  input sample valid.
- in_data  in  DW  input sample.
- in_ready  out  1  block accepts in_data this cycle.
- out_valid  out  1  result valid.
- out_data  out  DW  result.
- out_ready  in  1  sink accepts result.
- fir_ctrl  out  2  engine command: 00 idle/access, 10 clear, 01 start.
- fir_din  out  DW  engine write data.
- fir_addr  out  AW  engine address.
- fir_dout  in  DW  engine read data.
- fir_bsy  in  1  engine busy.
- busy  out  1  frame in progress (state != IDLE).
- done  out  1  one-cycle pulse after last result handshake.
- err  out  1  poll timeout; sticky until next accepted go.

Behaviour:
- Reset (rst==0 at an edge): state IDLE; fir_ctrl=00, fir_din=0, fir_addr=0, in_ready=0, out_valid=0, out_data=0, busy=0, done=0, err=0; counters 0.
- Reset mid-frame aborts at the next edge. No partial outputs are held.
- All outputs are registered.
- IDLE: go=1 -> CLR; clears err.
- CLR: fir_ctrl=10 for exactly 1 cycle -> GAP.
- GAP: fir_ctrl=00 for 1 cycle -> LOAD, k=0.
- LOAD:
  - in_ready=1. On in_valid&in_ready: fir_din<=in_data, fir_addr<=(k+1)*STRIDE, k++.
  - Sample 0 is also latched into s0.
  - No handshake: fir_din/fir_addr hold (rewrite is idempotent).
  - After the Nth handshake: in_ready drops the next cycle -> LOAD0.
- LOAD0: fir_din<=s0, fir_addr<=0 for 1 cycle -> START.
- START: fir_ctrl=01 for 1 cycle -> STOP.
- STOP: fir_ctrl=00 for 1 cycle -> SETTLE (1 cycle, bsy ignored) -> POLL.
- POLL:
  - Sample fir_bsy each cycle; first cycle with fir_bsy==0 -> RADDR, k=0.
  - Poll counter reaches TIMEOUT with bsy still 1: err<=1, busy<=0, no done -> IDLE.
- RADDR: fir_addr<=(k+1)*STRIDE -> RWAIT.
- RWAIT: hold for RD_LAT cycles, then capture out_data<=fir_dout, out_valid<=1 -> EMIT.
- EMIT:
  - Hold out_valid/out_data until out_ready.
  - On handshake: out_valid<=0; k++. If k<N -> RADDR; else done<=1 for 1 cycle -> IDLE.
- Address arithmetic: computed modulo 2^AW; (k+1)*STRIDE never wraps for defaults (max 144).
- go while busy is ignored; go with rst==0 is ignored.
- Ports fir_* are driven only per the state rules above. fir_ctrl is 00 in all states except CLR/START.
- Latency, default params, no stalls: go -> first in_ready = 3 cycles. Last sample -> START = 2 cycles.

Test Plan:
- Nominal, N=36: samples 1..36 streamed back-to-back; model engine returns addr/4+100.
  - Writes land at addr 4..144 with data 1..36, then addr 0 = 1.
  - One 10 pulse, one 01 pulse.
  - Outputs 101..136 in order; done pulses once; err=0.
- Input stall, N=4: in_valid toggles 1,0,1,0...
  - Exactly 4 writes at 4,8,12,16; fir_addr/fir_din hold during gaps.
  - Then addr 0 gets s0.
- Busy hold: engine holds bsy=1 for 50 cycles after start.
  - No read address issued before bsy falls; first RADDR the cycle after bsy==0 sampled.
- Output backpressure: out_ready low 5 cycles on result 3.
  - out_data stable, out_valid high throughout; no address advance.
  - All 36 results still correct.
- Timeout, TIMEOUT=16: bsy stuck 1.
  - err=1 at poll cycle 16; busy=0; done never pulses.
  - Next go clears err.
- Reset mid-EMIT: rst=0 for 1 cycle.
  - All outputs at reset values next edge; go ignored while rst=0.
  - A fresh frame afterwards completes correctly.
